// File: rtl/id_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake plus the decoded bundle.
// master = the surrounding pipeline (fetch/execute side); slave = the decode stage.
interface id_stage_if #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int IW  = 32,
    parameter int AW  = 32
);
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [IW-1:0]  in_inst;
    logic [AW-1:0]  in_pc;
    logic           out_valid;
    logic           out_ready;
    logic [AW-1:0]  out_pc;
    logic [RFW-1:0] addrA;
    logic [RFW-1:0] addrB;
    logic [RFW-1:0] rd;
    logic [DW-1:0]  imm;
    logic [2:0]     fmt;
    logic           rs1_used;
    logic           rs2_used;
    logic           rd_we;
    logic           illegal;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, addrA, addrB, rd, imm, fmt,
               rs1_used, rs2_used, rd_we, illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, addrA, addrB, rd, imm, fmt,
               rs1_used, rs2_used, rd_we, illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register indices, sign-extended immediate, format, use flags, illegal.
// Latency: 1 cycle from input transfer to registered bundle.
// Backpressure: single holding register; in_ready = !out_valid | out_ready, outputs frozen while stalled.
module id_stage #(
    parameter int RFW = 5,
    parameter int DW  = 32,
    parameter int IW  = 32,
    parameter int AW  = 32
) (
    input  logic     clk,
    input  logic     rst,
    id_stage_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_X = 3'd7
    } fmt_e;

    localparam logic [4:0] OP_OP     = 5'b01100;
    localparam logic [4:0] OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    typedef struct packed {
        logic [AW-1:0]  pc;
        logic [RFW-1:0] addr_a;
        logic [RFW-1:0] addr_b;
        logic [RFW-1:0] rd;
        logic [DW-1:0]  imm;
        logic [2:0]     fmt;
        logic           rs1_used;
        logic           rs2_used;
        logic           rd_we;
        logic           illegal;
    } bundle_t;

    logic [31:0]        iw;
    fmt_e               d_fmt;
    logic               is_sys;
    logic signed [31:0] imm32;
    bundle_t            dec;
    bundle_t            q;
    logic               vld_q;
    logic               take;

    assign iw   = bus.in_inst[31:0];
    assign take = bus.in_valid & bus.in_ready;

    always_comb begin
        d_fmt  = FMT_X;
        is_sys = 1'b0;
        if (iw[1:0] == 2'b11) begin
            case (iw[6:2])
                OP_OP:                      d_fmt = FMT_R;
                OP_IMM, OP_LOAD, OP_JALR:   d_fmt = FMT_I;
                OP_SYSTEM: begin
                    d_fmt  = FMT_I;
                    is_sys = 1'b1;
                end
                OP_STORE:                   d_fmt = FMT_S;
                OP_BRANCH:                  d_fmt = FMT_B;
                OP_LUI, OP_AUIPC:           d_fmt = FMT_U;
                OP_JAL:                     d_fmt = FMT_J;
                default:                    d_fmt = FMT_X;
            endcase
        end

        case (d_fmt)
            FMT_I:   imm32 = {{20{iw[31]}}, iw[31:20]};
            FMT_S:   imm32 = {{20{iw[31]}}, iw[31:25], iw[11:7]};
            FMT_B:   imm32 = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
            FMT_U:   imm32 = {iw[31:12], 12'b0};
            FMT_J:   imm32 = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        // Register fields are zeroed when unused so the register file never sees stale indices.
        dec          = '0;
        dec.pc       = bus.in_pc;
        dec.fmt      = d_fmt;
        dec.imm      = DW'(imm32);
        dec.illegal  = (d_fmt == FMT_X);
        dec.rs1_used = (d_fmt inside {FMT_R, FMT_I, FMT_S, FMT_B});
        dec.rs2_used = (d_fmt inside {FMT_R, FMT_S, FMT_B});
        dec.rd_we    = (d_fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && !is_sys
                       && (iw[11:7] != 5'd0);
        dec.addr_a   = dec.rs1_used ? RFW'(iw[19:15]) : '0;
        dec.addr_b   = dec.rs2_used ? RFW'(iw[24:20]) : '0;
        dec.rd       = dec.rd_we    ? RFW'(iw[11:7])  : '0;
    end

    // Flush outranks the input transfer so a redirected instruction is never latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            q     <= '0;
        end else if (bus.flush) begin
            vld_q <= 1'b0;
        end else if (take) begin
            vld_q <= 1'b1;
            q     <= dec;
        end else if (bus.out_ready) begin
            vld_q <= 1'b0;
        end
    end

    assign bus.in_ready  = !vld_q | bus.out_ready;
    assign bus.out_valid = vld_q;
    assign bus.out_pc    = q.pc;
    assign bus.addrA     = q.addr_a;
    assign bus.addrB     = q.addr_b;
    assign bus.rd        = q.rd;
    assign bus.imm       = q.imm;
    assign bus.fmt       = q.fmt;
    assign bus.rs1_used  = q.rs1_used;
    assign bus.rs2_used  = q.rs2_used;
    assign bus.rd_we     = q.rd_we;
    assign bus.illegal   = q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed decode vectors, stall/flush/reset cases, then random traffic.
module tb_id_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        u1;
        logic        u2;
        logic        we;
        logic        ill;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic mv;
    exp_t mb;
    logic [4:0] ops [10] = '{5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b11100,
                             5'b01000, 5'b11000, 5'b01101, 5'b00101, 5'b11011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decode from the ISA rules, immediates built as signed integer sums.
    function automatic exp_t ref_decode(input logic [31:0] x, input logic [31:0] pc);
        exp_t e;
        int   s;
        int   v;
        bit   sys;
        e   = '0;
        e.pc = pc;
        s   = x[31] ? -1 : 0;
        v   = 0;
        sys = (x[6:2] == 5'b11100);
        if (x[1:0] != 2'b11) e.fmt = 3'd7;
        else case (x[6:2])
            5'b01100:                               e.fmt = 3'd0;
            5'b00100, 5'b00000, 5'b11001, 5'b11100: e.fmt = 3'd1;
            5'b01000:                               e.fmt = 3'd2;
            5'b11000:                               e.fmt = 3'd3;
            5'b01101, 5'b00101:                     e.fmt = 3'd4;
            5'b11011:                               e.fmt = 3'd5;
            default:                                e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: v = s * 4096 + int'(x[31:20]);
            3'd2: v = s * 4096 + int'(x[31:25]) * 32 + int'(x[11:7]);
            3'd3: v = s * 4096 + int'(x[7]) * 2048 + int'(x[30:25]) * 32 + int'(x[11:8]) * 2;
            3'd4: v = int'(x[31:12]) * 4096;
            3'd5: v = s * 1048576 + int'(x[19:12]) * 4096 + int'(x[20]) * 2048
                      + int'(x[30:21]) * 2;
            default: v = 0;
        endcase
        e.imm = v;
        e.u1  = e.fmt inside {3'd0, 3'd1, 3'd2, 3'd3};
        e.u2  = e.fmt inside {3'd0, 3'd2, 3'd3};
        e.we  = (e.fmt inside {3'd0, 3'd1, 3'd4, 3'd5}) && !sys && (x[11:7] != 5'd0);
        e.a   = e.u1 ? x[19:15] : 5'd0;
        e.b   = e.u2 ? x[24:20] : 5'd0;
        e.rd  = e.we ? x[11:7]  : 5'd0;
        e.ill = (e.fmt == 3'd7);
        return e;
    endfunction

    // One clock: drive inputs, compare the visible state at negedge, then advance the model.
    task automatic step(input bit v, input logic [31:0] inst, input logic [31:0] pc,
                        input bit ordy, input bit fl, input bit rs);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = rs;
        @(negedge clk);
        check("in_ready",  64'(bus.in_ready),  64'(!mv || ordy));
        check("out_valid", 64'(bus.out_valid), 64'(mv));
        check("out_pc",    64'(bus.out_pc),    64'(mb.pc));
        check("addrA",     64'(bus.addrA),     64'(mb.a));
        check("addrB",     64'(bus.addrB),     64'(mb.b));
        check("rd",        64'(bus.rd),        64'(mb.rd));
        check("imm",       64'(bus.imm),       64'(mb.imm));
        check("fmt",       64'(bus.fmt),       64'(mb.fmt));
        check("rs1_used",  64'(bus.rs1_used),  64'(mb.u1));
        check("rs2_used",  64'(bus.rs2_used),  64'(mb.u2));
        check("rd_we",     64'(bus.rd_we),     64'(mb.we));
        check("illegal",   64'(bus.illegal),   64'(mb.ill));
        @(posedge clk);
        if (rs) begin
            mv = 1'b0;
            mb = '0;
        end else if (fl) begin
            mv = 1'b0;
        end else if (v && (!mv || ordy)) begin
            mv = 1'b1;
            mb = ref_decode(inst, pc);
        end else if (ordy) begin
            mv = 1'b0;
        end
        #1;
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rdn, input logic [4:0] rs1n);
        return {12'h001, rs1n, 3'b000, rdn, 7'b0010011};
    endfunction

    initial begin
        logic [31:0] inst;
        bus.in_valid  = 1'b0;
        bus.in_inst   = '0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mv = 1'b0;
        mb = '0;

        step(0, 32'h0, 32'h0, 1, 0, 1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_imm",       64'(bus.imm),       64'd0);

        step(1, 32'hFFF10093, 32'h100, 1, 0, 0);
        check("t1_fmt",      64'(bus.fmt),      64'd1);
        check("t1_addrA",    64'(bus.addrA),    64'd2);
        check("t1_rd",       64'(bus.rd),       64'd1);
        check("t1_imm",      64'(bus.imm),      64'hFFFFFFFF);
        check("t1_rd_we",    64'(bus.rd_we),    64'd1);
        check("t1_rs2_used", 64'(bus.rs2_used), 64'd0);

        step(1, 32'h123452B7, 32'h104, 1, 0, 0);
        check("t2_fmt",      64'(bus.fmt),      64'd4);
        check("t2_imm",      64'(bus.imm),      64'h12345000);
        check("t2_rd",       64'(bus.rd),       64'd5);
        check("t2_rs1_used", 64'(bus.rs1_used), 64'd0);

        step(1, 32'hFE208EE3, 32'h108, 1, 0, 0);
        check("t3_fmt",   64'(bus.fmt),   64'd3);
        check("t3_imm",   64'(bus.imm),   64'hFFFFFFFC);
        check("t3_addrA", 64'(bus.addrA), 64'd1);
        check("t3_addrB", 64'(bus.addrB), 64'd2);
        check("t3_rd_we", 64'(bus.rd_we), 64'd0);

        step(1, 32'h0020A423, 32'h10C, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00000033, 32'h110, 0, 0, 0);
            check("t4_in_ready", 64'(bus.in_ready), 64'd0);
            check("t4_imm",      64'(bus.imm),      64'd8);
            check("t4_pc",       64'(bus.out_pc),   64'h10C);
        end
        step(1, 32'h00000033, 32'h110, 1, 0, 0);
        check("t4_release_pc", 64'(bus.out_pc), 64'h110);

        step(1, 32'h00000000, 32'h200, 1, 0, 0);
        check("t5_illegal", 64'(bus.illegal), 64'd1);
        check("t5_fmt",     64'(bus.fmt),     64'd7);
        step(1, 32'h00000033, 32'h204, 1, 0, 0);
        check("t5_rd_we",   64'(bus.rd_we),   64'd0);
        check("t5_fmt_r",   64'(bus.fmt),     64'd0);

        for (int i = 0; i < 6; i++) begin
            step(1, addi(5'(i + 1), 5'd3), 32'h300 + 32'(i * 4), 1, i == 3, 0);
            if (i == 3) check("t6_flush_vld", 64'(bus.out_valid), 64'd0);
            if (i == 4) check("t6_after_flush_pc", 64'(bus.out_pc), 64'h310);
        end
        step(1, addi(5'd7, 5'd1), 32'h400, 0, 0, 0);
        step(1, addi(5'd8, 5'd1), 32'h404, 0, 0, 1);
        check("t6_rst_vld", 64'(bus.out_valid), 64'd0);
        check("t6_rst_pc",  64'(bus.out_pc),    64'd0);

        repeat (400) begin
            inst = $urandom;
            if ($urandom_range(0, 9) != 0) inst[6:0] = {ops[$urandom_range(0, 9)], 2'b11};
            step($urandom_range(0, 9) < 7, inst, $urandom, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
        end
        step(0, 32'h0, 32'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
